// File: rtl/video_pattern_gen.sv
// video_pattern_gen: turns encoder pixel coordinates into a test-pattern colour.
// Six patterns, cycled by a debounced push-button; a mode change is applied
// only at frame start (cx==0 && cy==0) so no frame mixes two patterns.
// Optional build macro: PATTERN_CROSSHAIR_EN adds a white centre crosshair
// over every pattern inside the active region.
module video_pattern_gen #(
    parameter int SCREEN_WIDTH    = 1280,
    parameter int SCREEN_HEIGHT   = 720,
    parameter int BIT_WIDTH       = 11,
    parameter int BIT_HEIGHT      = 10,
    parameter int DEBOUNCE_CYCLES = 742500,
    parameter int BAR_SPEED       = 4,
    parameter int CHECKER_LOG2    = 5,
    parameter int RAMP_SHIFT      = 2
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    input  logic [BIT_WIDTH-1:0]  cx,
    input  logic [BIT_HEIGHT-1:0] cy,
    input  logic [BIT_WIDTH-1:0]  screen_start_x,
    input  logic [BIT_HEIGHT-1:0] screen_start_y,
    input  logic                  btn_next,
    output logic [23:0]           rgb,
    output logic [2:0]            mode,
    output logic                  frame_tick
);

    typedef enum logic [2:0] {
        MODE_THIRDS     = 3'd0,
        MODE_BARS       = 3'd1,
        MODE_CHECKER    = 3'd2,
        MODE_RAMP       = 3'd3,
        MODE_MOVING_BAR = 3'd4,
        MODE_BORDER     = 3'd5
    } mode_e;

    localparam int LP_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [LP_CNT_W-1:0]   LP_CNT_MAX   = LP_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BIT_WIDTH:0]    LP_W_EXT     = (BIT_WIDTH+1)'(SCREEN_WIDTH);
    localparam logic [BIT_HEIGHT:0]   LP_H_EXT     = (BIT_HEIGHT+1)'(SCREEN_HEIGHT);
    localparam logic [BIT_WIDTH-1:0]  LP_W         = BIT_WIDTH'(SCREEN_WIDTH);
    localparam logic [BIT_WIDTH-1:0]  LP_W_LAST    = BIT_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [BIT_HEIGHT-1:0] LP_H_LAST    = BIT_HEIGHT'(SCREEN_HEIGHT - 1);
    localparam logic [BIT_HEIGHT-1:0] LP_H_THIRD   = BIT_HEIGHT'(SCREEN_HEIGHT / 3);
    localparam logic [BIT_HEIGHT-1:0] LP_H_2THIRD  = BIT_HEIGHT'((2 * SCREEN_HEIGHT) / 3);
    localparam logic [BIT_WIDTH-1:0]  LP_RAMP_MAX  = BIT_WIDTH'(255);
    localparam logic [BIT_WIDTH:0]    LP_BAR_WIDTH = (BIT_WIDTH+1)'(16);
    localparam logic [BIT_WIDTH:0]    LP_BAR_STEP  = (BIT_WIDTH+1)'(BAR_SPEED);
`ifdef PATTERN_CROSSHAIR_EN
    localparam logic [BIT_WIDTH-1:0]  LP_X_MID     = BIT_WIDTH'(SCREEN_WIDTH / 2);
    localparam logic [BIT_HEIGHT-1:0] LP_Y_MID     = BIT_HEIGHT'(SCREEN_HEIGHT / 2);
`endif

    // Registers
    logic [1:0]            r_sync;
    logic                  r_db_level;
    logic [LP_CNT_W-1:0]   r_db_cnt;
    logic                  r_pending;
    mode_e                 r_mode;
    logic [BIT_WIDTH-1:0]  r_bar_x;
    logic [23:0]           r_rgb;
    logic                  r_frame_tick;

    // Combinational signals
    logic                  w_btn_sync;
    logic                  w_press;
    logic                  w_frame_start;
    logic [BIT_WIDTH-1:0]  w_ax;
    logic [BIT_HEIGHT-1:0] w_ay;
    logic                  w_active;
    logic [2:0]            w_bar_idx;
    logic [BIT_WIDTH-1:0]  w_ramp;
    logic [7:0]            w_grey;
    logic [BIT_WIDTH:0]    w_bar_sum;
    logic [BIT_WIDTH-1:0]  w_bar_next;
    logic                  w_pending_next;
    mode_e                 w_mode_next;
    logic [23:0]           w_pattern;

    assign w_btn_sync    = r_sync[1];
    assign w_frame_start = (cx == '0) && (cy == '0);
    assign w_ax          = cx - screen_start_x;
    assign w_ay          = cy - screen_start_y;
    // ax/ay are only meaningful once cx/cy are at or past the start, so test that first.
    assign w_active      = (cx >= screen_start_x) && ({1'b0, w_ax} < LP_W_EXT) &&
                           (cy >= screen_start_y) && ({1'b0, w_ay} < LP_H_EXT);
    // A debounced 0->1 flip happens on exactly this cycle.
    assign w_press       = (w_btn_sync != r_db_level) && (r_db_cnt == LP_CNT_MAX) && w_btn_sync;

    // Synchronize the raw button and accept a level only after it has held long enough.
    always_ff @(posedge clk_pixel) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples
        // pre-edge values; blocking here would create order-dependent simulation.
        if (reset) begin
            r_sync     <= '0;
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], btn_next};
            if (w_btn_sync == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == LP_CNT_MAX) begin
                r_db_level <= w_btn_sync;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + LP_CNT_W'(1);
            end
        end
    end

    // Next mode / pending: presses are latched, then applied at frame start.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves a
        // signal unassigned and no latch is inferred.
        w_mode_next    = r_mode;
        w_pending_next = r_pending;
        if (w_frame_start && (r_pending || w_press)) begin
            w_mode_next    = (r_mode == MODE_BORDER) ? MODE_THIRDS : mode_e'(r_mode + 3'd1);
            w_pending_next = 1'b0;
        end else if (w_press) begin
            w_pending_next = 1'b1;
        end
    end

    // Moving-bar position: advance one step per frame, folding back past the right edge.
    always_comb begin
        w_bar_sum  = {1'b0, r_bar_x} + LP_BAR_STEP;
        w_bar_next = w_bar_sum[BIT_WIDTH-1:0];
        if (w_bar_sum >= LP_W_EXT) begin
            // The true result is below SCREEN_WIDTH, so modular subtraction is exact.
            w_bar_next = w_bar_sum[BIT_WIDTH-1:0] - LP_W;
        end
    end

    // Mode, pending flag and bar position registers.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_mode    <= MODE_THIRDS;
            r_pending <= 1'b0;
            r_bar_x   <= '0;
        end else begin
            r_mode    <= w_mode_next;
            r_pending <= w_pending_next;
            if (w_frame_start) begin
                r_bar_x <= w_bar_next;
            end
        end
    end

    // Colour-bar index: how many eighth-width boundaries ax has passed.
    always_comb begin
        w_bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (w_ax >= BIT_WIDTH'((i * SCREEN_WIDTH) / 8)) begin
                w_bar_idx = 3'(i);
            end
        end
    end

    assign w_ramp = w_ax >> RAMP_SHIFT;
    assign w_grey = (w_ramp > LP_RAMP_MAX) ? 8'hFF : w_ramp[7:0];

    // Pattern colour for the applied mode at the current coordinate.
    always_comb begin
        w_pattern = 24'h000000;
        case (r_mode)
            MODE_THIRDS: begin
                if (w_ay < LP_H_THIRD)       w_pattern = 24'hFF0000;
                else if (w_ay < LP_H_2THIRD) w_pattern = 24'h00FF00;
                else                         w_pattern = 24'h0000FF;
            end
            MODE_BARS: begin
                case (w_bar_idx)
                    3'd0:    w_pattern = 24'hFFFFFF;
                    3'd1:    w_pattern = 24'hFFFF00;
                    3'd2:    w_pattern = 24'h00FFFF;
                    3'd3:    w_pattern = 24'h00FF00;
                    3'd4:    w_pattern = 24'hFF00FF;
                    3'd5:    w_pattern = 24'hFF0000;
                    3'd6:    w_pattern = 24'h0000FF;
                    default: w_pattern = 24'h000000;
                endcase
            end
            MODE_CHECKER: begin
                if (w_ax[CHECKER_LOG2] ^ w_ay[CHECKER_LOG2]) w_pattern = 24'hFFFFFF;
            end
            MODE_RAMP: begin
                w_pattern = {w_grey, w_grey, w_grey};
            end
            MODE_MOVING_BAR: begin
                if (({1'b0, w_ax} >= {1'b0, r_bar_x}) &&
                    ({1'b0, w_ax} < ({1'b0, r_bar_x} + LP_BAR_WIDTH))) begin
                    w_pattern = 24'hFFFFFF;
                end
            end
            MODE_BORDER: begin
                if (w_ax == '0)                              w_pattern = 24'hFF0000;
                else if (w_ay == '0)                         w_pattern = 24'h00FF00;
                else if ((w_ax == LP_W_LAST) || (w_ay == LP_H_LAST)) w_pattern = 24'h0000FF;
            end
            default: w_pattern = 24'h000000;
        endcase
`ifdef PATTERN_CROSSHAIR_EN
        if ((w_ax == LP_X_MID) || (w_ay == LP_Y_MID)) begin
            w_pattern = 24'hFFFFFF;
        end
`else
`endif
    end

    // Output registers: colour blanked outside the active region, frame pulse one clock late.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_rgb        <= 24'h000000;
            r_frame_tick <= 1'b0;
        end else begin
            r_rgb        <= w_active ? w_pattern : 24'h000000;
            r_frame_tick <= w_frame_start;
        end
    end

    assign rgb        = r_rgb;
    assign mode       = r_mode;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Testbench for video_pattern_gen: directed steps, expected colour/tick pushed
// to a scoreboard when coordinates are driven and popped one clock later.
// Honours PATTERN_CROSSHAIR_EN in its reference model when defined.
module tb_video_pattern_gen;

    localparam int W  = 1280;
    localparam int H  = 720;
    localparam int DB = 200;
    localparam int BAR_SPEED = 4;

    logic        clk_pixel = 1'b0;
    logic        reset;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic [10:0] screen_start_x;
    logic [9:0]  screen_start_y;
    logic        btn_next;
    logic [23:0] rgb;
    logic [2:0]  mode;
    logic        frame_tick;

    video_pattern_gen #(
        .SCREEN_WIDTH    (W),
        .SCREEN_HEIGHT   (H),
        .BIT_WIDTH       (11),
        .BIT_HEIGHT      (10),
        .DEBOUNCE_CYCLES (DB),
        .BAR_SPEED       (BAR_SPEED),
        .CHECKER_LOG2    (5),
        .RAMP_SHIFT      (2)
    ) dut (
        .clk_pixel      (clk_pixel),
        .reset          (reset),
        .cx             (cx),
        .cy             (cy),
        .screen_start_x (screen_start_x),
        .screen_start_y (screen_start_y),
        .btn_next       (btn_next),
        .rgb            (rgb),
        .mode           (mode),
        .frame_tick     (frame_tick)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        logic [23:0] rgb;
        logic        tick;
        string       tag;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_mode    = 0;
    int m_bar     = 0;
    int m_pending = 0;
    int m_ssx     = 0;
    int m_ssy     = 0;

    function automatic logic [23:0] model_rgb(input int md, input int bx, input int x, input int y);
        int ax;
        int ay;
        int g;
        ax = x - m_ssx;
        ay = y - m_ssy;
        if (ax < 0 || ax >= W || ay < 0 || ay >= H) return 24'h000000;
`ifdef PATTERN_CROSSHAIR_EN
        if (ax == W / 2 || ay == H / 2) return 24'hFFFFFF;
`endif
        case (md)
            0: begin
                if (ay < 240) return 24'hFF0000;
                if (ay < 480) return 24'h00FF00;
                return 24'h0000FF;
            end
            1: begin
                case (ax / (W / 8))
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2: return ((((ax / 32) % 2) != ((ay / 32) % 2))) ? 24'hFFFFFF : 24'h000000;
            3: begin
                g = ax / 4;
                if (g > 255) g = 255;
                return {g[7:0], g[7:0], g[7:0]};
            end
            4: return (ax >= bx && ax < bx + 16) ? 24'hFFFFFF : 24'h000000;
            5: begin
                if (ax == 0) return 24'hFF0000;
                if (ay == 0) return 24'h00FF00;
                if (ax == W - 1 || ay == H - 1) return 24'h0000FF;
                return 24'h000000;
            end
            default: return 24'h000000;
        endcase
    endfunction

    task automatic check_mode(input string tag);
        n_checks++;
        assert (mode === m_mode[2:0]) else begin
            n_fail++;
            $error("FAIL %s mode: observed %0d expected %0d", tag, mode, m_mode);
        end
    endtask

    task automatic check_out();
        exp_t e;
        n_checks++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard empty: observed rgb %06h expected an entry", rgb);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            assert (rgb === e.rgb) else begin
                n_fail++;
                $error("FAIL %s rgb: observed %06h expected %06h", e.tag, rgb, e.rgb);
            end
            n_checks++;
            assert (frame_tick === e.tick) else begin
                n_fail++;
                $error("FAIL %s frame_tick: observed %b expected %b", e.tag, frame_tick, e.tick);
            end
        end
    endtask

    // Drive one coordinate, record the expected result, check it one clock later.
    task automatic step(input int x, input int y, input string tag);
        exp_t e;
        @(negedge clk_pixel);
        cx = 11'(x);
        cy = 10'(y);
        e.rgb  = model_rgb(m_mode, m_bar, x, y);
        e.tick = (x == 0 && y == 0);
        e.tag  = tag;
        sb.push_back(e);
        if (x == 0 && y == 0) begin
            m_bar = (m_bar + BAR_SPEED >= W) ? m_bar + BAR_SPEED - W : m_bar + BAR_SPEED;
            if (m_pending != 0) begin
                m_mode    = (m_mode == 5) ? 0 : m_mode + 1;
                m_pending = 0;
            end
        end
        @(posedge clk_pixel);
        #1;
        check_out();
        check_mode(tag);
    endtask

    // A press long enough to be accepted, then a release long enough to settle.
    task automatic press();
        @(negedge clk_pixel);
        cx = 11'd5;
        cy = 10'd5;
        btn_next = 1'b1;
        repeat (DB + 5) @(negedge clk_pixel);
        btn_next = 1'b0;
        repeat (DB + 5) @(negedge clk_pixel);
        m_pending = 1;
    endtask

    task automatic new_mode();
        press();
        step(0, 0, "frame_start");
    endtask

    initial begin
        reset = 1'b1;
        cx = 11'd5;
        cy = 10'd5;
        screen_start_x = '0;
        screen_start_y = '0;
        btn_next = 1'b0;
        repeat (3) @(negedge clk_pixel);
        #1;
        n_checks++;
        assert (rgb === 24'h000000) else begin
            n_fail++;
            $error("FAIL reset rgb: observed %06h expected 000000", rgb);
        end
        n_checks++;
        assert (frame_tick === 1'b0) else begin
            n_fail++;
            $error("FAIL reset frame_tick: observed %b expected 0", frame_tick);
        end
        check_mode("reset");
        reset = 1'b0;

        // Mode 0: thirds, and blanking outside the active area
        step(10, 0,   "m0_y0");
        step(10, 239, "m0_y239");
        step(10, 240, "m0_y240");
        step(10, 480, "m0_y480");
        step(10, 719, "m0_y719");
        step(1280, 10, "m0_x1280");
        step(2000, 10, "m0_x2000");
        step(10, 720, "m0_y720");
        step(0, 0, "m0_frame");

        // Non-zero screen start
        screen_start_x = 11'd100;
        screen_start_y = 10'd20;
        m_ssx = 100;
        m_ssy = 20;
        step(99, 20,   "ss_left_out");
        step(100, 20,  "ss_origin");
        step(1379, 20, "ss_right_in");
        step(1380, 20, "ss_right_out");
        step(100, 19,  "ss_top_out");
        step(100, 739, "ss_bottom_in");
        step(100, 740, "ss_bottom_out");
        screen_start_x = '0;
        screen_start_y = '0;
        m_ssx = 0;
        m_ssy = 0;

        // Press mid-frame: nothing changes until frame start
        press();
        step(10, 10, "pending_hold");
        step(0, 0,   "apply_1");

        // Mode 1 bars
        for (int i = 0; i < 8; i++) step(80 + 160 * i, 600, "m1_bar");
        step(159, 600, "m1_bar0_edge");
        step(160, 600, "m1_bar1_edge");
        step(640, 100, "m1_640_100");
        step(100, 360, "m1_100_360");
        step(100, 100, "m1_100_100");

        // Two presses in one frame collapse into one advance
        press();
        press();
        step(10, 10, "two_press_hold");
        step(0, 0,   "apply_2");

        // Mode 2 checkerboard
        step(32, 0,  "m2_32_0");
        step(32, 32, "m2_32_32");
        step(31, 0,  "m2_31_0");
        step(5, 40,  "m2_5_40");

        // Mode 3 ramp
        new_mode();
        step(0, 5,    "m3_ax0");
        step(400, 5,  "m3_ax400");
        step(1019, 5, "m3_ax1019");
        step(1279, 5, "m3_ax1279");

        // Mode 4 moving bar over 320 frames, including the 1276 -> 0 wrap
        new_mode();
        for (int f = 0; f < 320; f++) begin
            step(0, 0, "m4_frame");
            step(m_bar, 300, "m4_bar_left");
            step(m_bar + 15, 300, "m4_bar_right");
            step(m_bar + 16, 300, "m4_after_bar");
            step((m_bar + W - 1) % W, 300, "m4_before_bar");
        end

        // Mode 5 border
        new_mode();
        step(0, 5,      "m5_left");
        step(5, 0,      "m5_top");
        step(1279, 5,   "m5_right");
        step(5, 719,    "m5_bottom");
        step(1279, 0,   "m5_top_right");
        step(0, 719,    "m5_bottom_left");
        step(5, 5,      "m5_inner");

        // Wrap back to mode 0
        new_mode();
        step(10, 300, "wrap_m0");

        // Short glitch is rejected
        @(negedge clk_pixel);
        cx = 11'd5;
        cy = 10'd5;
        btn_next = 1'b1;
        repeat (100) @(negedge clk_pixel);
        btn_next = 1'b0;
        repeat (DB + 5) @(negedge clk_pixel);
        step(0, 0, "glitch_frame");
        step(10, 300, "glitch_m0");

        // Back to mode 1, then reset mid-frame
        new_mode();
        step(640, 360, "m1_centre");
        @(negedge clk_pixel);
        reset = 1'b1;
        cx = 11'd640;
        cy = 10'd360;
        begin
            exp_t e;
            e.rgb  = 24'h000000;
            e.tick = 1'b0;
            e.tag  = "reset_mid";
            sb.push_back(e);
        end
        m_mode    = 0;
        m_bar     = 0;
        m_pending = 0;
        @(posedge clk_pixel);
        #1;
        check_out();
        check_mode("reset_mid");
        reset = 1'b0;
        step(10, 100, "post_reset_m0");
        step(10, 500, "post_reset_m0_blue");

        n_checks++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard drain: observed %0d entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
